// File: rtl/memory_arbiter.sv
// Two-requester (core, loader) arbiter in front of a single-port synchronous data memory.
// Round-robin on ties; one memory access per grant, done pulse returned to the owner.
module memory_arbiter (
    input  logic       clk,
    input  logic       resetN,
    input  logic       coreReq,
    input  logic       coreWrite,
    input  logic [7:0] coreAddress,
    input  logic [7:0] coreWriteData,
    output logic [7:0] coreReadData,
    output logic       coreDone,
    output logic       coreStall,
    input  logic       loadReq,
    input  logic       loadWrite,
    input  logic [7:0] loadAddress,
    input  logic [7:0] loadWriteData,
    output logic [7:0] loadReadData,
    output logic       loadDone,
    output logic [7:0] memAddress,
    output logic       memWrite,
    output logic       memRead,
    output logic [7:0] memWriteData,
    input  logic [7:0] memReadData,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic {OWN_CORE = 1'b0, OWN_LOAD = 1'b1} owner_t;

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     last_grant_q, last_grant_d;
    owner_t     grant;
    logic       wr_q, wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       core_done_q, core_done_d;
    logic       load_done_q, load_done_d;
    logic [7:0] core_rdata_q, core_rdata_d;
    logic [7:0] load_rdata_q, load_rdata_d;

    always_comb begin
        if (coreReq && loadReq) begin
            grant = (last_grant_q == OWN_CORE) ? OWN_LOAD : OWN_CORE;
        end else if (coreReq) begin
            grant = OWN_CORE;
        end else begin
            grant = OWN_LOAD;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_done_d  = 1'b0;
        load_done_d  = 1'b0;
        core_rdata_d = core_rdata_q;
        load_rdata_d = load_rdata_q;
        case (state_q)
            IDLE: begin
                if (coreReq || loadReq) begin
                    owner_d = grant;
                    if (grant == OWN_CORE) begin
                        wr_d    = coreWrite;
                        addr_d  = coreAddress;
                        wdata_d = coreWriteData;
                    end else begin
                        wr_d    = loadWrite;
                        addr_d  = loadAddress;
                        wdata_d = loadWriteData;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    core_done_d = (owner_q == OWN_CORE);
                    load_done_d = (owner_q == OWN_LOAD);
                    state_d     = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Memory data is valid this cycle; captured so it appears with the done pulse.
                if (owner_q == OWN_CORE) begin
                    core_rdata_d = memReadData;
                    core_done_d  = 1'b1;
                end else begin
                    load_rdata_d = memReadData;
                    load_done_d  = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CORE;
            last_grant_q <= OWN_LOAD;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_done_q  <= 1'b0;
            load_done_q  <= 1'b0;
            core_rdata_q <= '0;
            load_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_done_q  <= core_done_d;
            load_done_q  <= load_done_d;
            core_rdata_q <= core_rdata_d;
            load_rdata_q <= load_rdata_d;
        end
    end

    // Memory command is decoded from state flops only, so reset removes it without a clock.
    assign memWrite     = (state_q == ACCESS) &&  wr_q;
    assign memRead      = (state_q == ACCESS) && !wr_q;
    assign memAddress   = (state_q == ACCESS) ? addr_q : '0;
    assign memWriteData = memWrite ? wdata_q : '0;

    assign coreDone     = core_done_q;
    assign loadDone     = load_done_q;
    assign coreReadData = core_rdata_q;
    assign loadReadData = load_rdata_q;
    assign coreStall    = coreReq && !core_done_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: drivers push expected transactions, a negedge
// monitor predicts grants/latencies from the arbitration rules and checks every cycle.
module tb_memory_arbiter;

    logic       clk = 1'b0;
    logic       resetN;
    logic       coreReq, coreWrite, loadReq, loadWrite;
    logic [7:0] coreAddress, coreWriteData, loadAddress, loadWriteData;
    logic [7:0] coreReadData, loadReadData, memAddress, memWriteData, memReadData;
    logic       coreDone, coreStall, loadDone, memWrite, memRead, busy;

    always #5 clk = ~clk;

    memory_arbiter dut (
        .clk(clk), .resetN(resetN),
        .coreReq(coreReq), .coreWrite(coreWrite), .coreAddress(coreAddress),
        .coreWriteData(coreWriteData), .coreReadData(coreReadData),
        .coreDone(coreDone), .coreStall(coreStall),
        .loadReq(loadReq), .loadWrite(loadWrite), .loadAddress(loadAddress),
        .loadWriteData(loadWriteData), .loadReadData(loadReadData), .loadDone(loadDone),
        .memAddress(memAddress), .memWrite(memWrite), .memRead(memRead),
        .memWriteData(memWriteData), .memReadData(memReadData), .busy(busy)
    );

    // Synchronous data memory seen by the arbiter.
    logic [7:0] tbmem [256];
    logic [7:0] model_mem [256];
    always @(posedge clk) begin
        if (memWrite) tbmem[memAddress] <= memWriteData;
        if (memRead)  memReadData <= tbmem[memAddress];
    end

    typedef struct {
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rd;
    } xact_t;

    xact_t core_q[$];
    xact_t load_q[$];
    bit    done_order[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, want, $time);
        end
    endtask

    // Monitor / reference model state.
    bit         mon_en = 1'b0;
    int         cyc = 0;
    bit         inflight = 1'b0, have_grant = 1'b0;
    bit         grant_own = 1'b0, fl_own = 1'b0, last_owner = 1'b1;
    int         done_cyc = 0;
    logic [7:0] rd_exp0 = '0, rd_exp1 = '0;
    bit         cmd_seen0 = 1'b0, cmd_seen1 = 1'b0;

    always @(negedge clk) begin
        xact_t h;
        bit    exp_cd, exp_ld, idle_cycle;
        cyc++;
        if (!mon_en) begin
            inflight = 0; have_grant = 0; last_owner = 1;
            rd_exp0 = '0; rd_exp1 = '0;
            core_q.delete(); load_q.delete();
        end else begin
            idle_cycle = !inflight && !have_grant;
            chk("mem_exclusive", int'(memWrite & memRead), 0);
            if (have_grant) begin
                have_grant = 0;
                if ((grant_own ? load_q.size() : core_q.size()) == 0) begin
                    checks++; failures++;
                    $display("FAIL grant_no_pending actual=grant%0d required=none @%0t", grant_own, $time);
                end else begin
                    if (grant_own) h = load_q[0]; else h = core_q[0];
                    chk("cmd_write", int'(memWrite), int'(h.w));
                    chk("cmd_read", int'(memRead), int'(!h.w));
                    chk("cmd_addr", int'(memAddress), int'(h.a));
                    if (h.w) chk("cmd_wdata", int'(memWriteData), int'(h.d));
                    inflight = 1;
                    fl_own   = grant_own;
                    done_cyc = cyc + (h.w ? 1 : 2);
                    if (grant_own) cmd_seen1 = 1; else cmd_seen0 = 1;
                end
            end else begin
                chk("no_cmd_write", int'(memWrite), 0);
                chk("no_cmd_read", int'(memRead), 0);
            end
            chk("busy", int'(busy), int'(!idle_cycle));
            exp_cd = inflight && (cyc == done_cyc) && !fl_own;
            exp_ld = inflight && (cyc == done_cyc) && fl_own;
            chk("core_done", int'(coreDone), int'(exp_cd));
            chk("load_done", int'(loadDone), int'(exp_ld));
            chk("core_stall", int'(coreStall), int'(coreReq && !exp_cd));
            if (idle_cycle || exp_cd || exp_ld) begin
                chk("mem_addr_zero", int'(memAddress), 0);
                chk("mem_wdata_zero", int'(memWriteData), 0);
            end
            if (exp_cd && core_q.size() > 0) begin
                h = core_q.pop_front();
                if (!h.w) rd_exp0 = h.rd;
                inflight = 0;
            end
            if (exp_ld && load_q.size() > 0) begin
                h = load_q.pop_front();
                if (!h.w) rd_exp1 = h.rd;
                inflight = 0;
            end
            chk("core_rdata", int'(coreReadData), int'(rd_exp0));
            chk("load_rdata", int'(loadReadData), int'(rd_exp1));
            if (idle_cycle && (coreReq || loadReq)) begin
                have_grant = 1;
                grant_own  = (coreReq && loadReq) ? !last_owner : !coreReq;
                last_owner = grant_own;
            end
        end
    end

    // One transaction for requester r (0 core, 1 load); lat counts cycles from the IDLE
    // cycle that sees the request to the cycle showing done. Inputs are scrambled after grant.
    task automatic xact(input bit r, input bit w, input logic [7:0] a,
                        input logic [7:0] d, output int lat);
        xact_t e;
        bit    scr;
        e.w = w; e.a = a; e.d = d;
        e.rd = w ? 8'h00 : model_mem[a];
        if (w) model_mem[a] = d;
        if (r) load_q.push_back(e); else core_q.push_back(e);
        @(posedge clk); #1;
        if (r) begin
            cmd_seen1 = 0; loadReq = 1; loadWrite = w; loadAddress = a; loadWriteData = d;
        end else begin
            cmd_seen0 = 0; coreReq = 1; coreWrite = w; coreAddress = a; coreWriteData = d;
        end
        lat = -1;
        scr = 0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk); #1;
            if ((r ? loadDone : coreDone) == 1'b1) begin
                lat = k;
                if (r) loadReq = 0; else coreReq = 0;
                done_order.push_back(r);
            end else if (!scr && (r ? cmd_seen1 : cmd_seen0)) begin
                scr = 1;
                if (r) begin
                    loadAddress = a ^ 8'h30; loadWriteData = ~d; loadWrite = !w;
                end else begin
                    coreAddress = a ^ 8'h30; coreWriteData = ~d; coreWrite = !w;
                end
            end
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL xact_timeout requester=%0d actual=no_done required=done", r);
            if (r) loadReq = 0; else coreReq = 0;
        end
    endtask

    task automatic order_chk(input string nm, input bit first, input bit second);
        chk({nm, "_count"}, done_order.size(), 2);
        if (done_order.size() == 2) begin
            chk({nm, "_first"}, int'(done_order[0]), int'(first));
            chk({nm, "_second"}, int'(done_order[1]), int'(second));
        end
        done_order.delete();
    endtask

    // Core holds its request high: back-to-back writes, then reads, with a load wedged in.
    task automatic hold_test();
        xact_t e;
        int    cd[$];
        int    ld;
        e.w = 1; e.a = 8'h30; e.d = 8'h5C; e.rd = 8'h00;
        model_mem[8'h30] = 8'h5C;
        repeat (3) core_q.push_back(e);
        @(posedge clk); #1;
        coreReq = 1; coreWrite = 1; coreAddress = 8'h30; coreWriteData = 8'h5C;
        ld = -1;
        for (int k = 0; k < 60 && !(cd.size() == 3 && ld >= 0); k++) begin
            @(negedge clk); #1;
            if (coreDone) begin
                cd.push_back(k);
                if (cd.size() == 2) begin
                    e.a = 8'hB0; e.d = 8'h3C;
                    model_mem[8'hB0] = 8'h3C;
                    load_q.push_back(e);
                    loadReq = 1; loadWrite = 1; loadAddress = 8'hB0; loadWriteData = 8'h3C;
                end
                if (cd.size() == 3) coreReq = 0;
            end
            if (loadDone) begin
                ld = k; loadReq = 0;
            end
        end
        chk("hold_wr_complete", int'(cd.size() == 3 && ld >= 0), 1);
        if (cd.size() == 3 && ld >= 0) begin
            chk("hold_wr_first_lat", cd[0], 2);
            chk("hold_wr_period", cd[1] - cd[0], 3);
            chk("hold_load_between", ld - cd[1], 3);
            chk("hold_core_after_load", cd[2] - ld, 3);
        end
        coreReq = 0; loadReq = 0;
        cd.delete();
        e.w = 0; e.a = 8'h30; e.rd = model_mem[8'h30];
        repeat (2) core_q.push_back(e);
        @(posedge clk); #1;
        coreReq = 1; coreWrite = 0; coreAddress = 8'h30;
        for (int k = 0; k < 40 && cd.size() < 2; k++) begin
            @(negedge clk); #1;
            if (coreDone) begin
                cd.push_back(k);
                if (cd.size() == 2) coreReq = 0;
            end
        end
        coreReq = 0;
        chk("hold_rd_complete", cd.size(), 2);
        if (cd.size() == 2) begin
            chk("hold_rd_first_lat", cd[0], 3);
            chk("hold_rd_period", cd[1] - cd[0], 4);
        end
    endtask

    task automatic reset_test();
        @(posedge clk); #1;
        mon_en = 0;
        coreReq = 1; coreWrite = 1; coreAddress = 8'h40; coreWriteData = 8'h77;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_memwrite", int'(memWrite), 1);
        #1 resetN = 0; coreReq = 0;
        #1;
        chk("rst_async_memwrite", int'(memWrite), 0);
        chk("rst_memread", int'(memRead), 0);
        chk("rst_memaddr", int'(memAddress), 0);
        chk("rst_memwdata", int'(memWriteData), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_core_done", int'(coreDone), 0);
        chk("rst_load_done", int'(loadDone), 0);
        chk("rst_core_stall", int'(coreStall), 0);
        chk("rst_core_rdata", int'(coreReadData), 0);
        chk("rst_load_rdata", int'(loadReadData), 0);
        @(posedge clk); #1 resetN = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", int'(coreDone), 0);
            chk("post_rst_idle", int'(busy), 0);
        end
        @(posedge clk); #1 mon_en = 1;
    endtask

    initial begin
        int lat, lat2;
        resetN = 1;
        coreReq = 0; coreWrite = 0; coreAddress = '0; coreWriteData = '0;
        loadReq = 0; loadWrite = 0; loadAddress = '0; loadWriteData = '0;
        for (int i = 0; i < 256; i++) begin
            tbmem[i]     = 8'(i * 5 + 1);
            model_mem[i] = 8'(i * 5 + 1);
        end
        #2 resetN = 0;
        #1;
        chk("reset_core_rdata", int'(coreReadData), 0);
        chk("reset_load_rdata", int'(loadReadData), 0);
        chk("reset_core_done", int'(coreDone), 0);
        chk("reset_load_done", int'(loadDone), 0);
        chk("reset_memwrite", int'(memWrite), 0);
        chk("reset_memread", int'(memRead), 0);
        chk("reset_memaddr", int'(memAddress), 0);
        chk("reset_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 resetN = 1; mon_en = 1;

        // First tie after reset goes to core; after a core-only grant the tie goes to load.
        done_order.delete();
        fork
            xact(1'b0, 1'b0, 8'h20, 8'h00, lat);
            xact(1'b1, 1'b1, 8'h90, 8'h66, lat2);
        join
        order_chk("tie_after_reset", 1'b0, 1'b1);
        xact(1'b0, 1'b1, 8'h21, 8'h11, lat);
        done_order.delete();
        fork
            xact(1'b0, 1'b1, 8'h22, 8'h12, lat);
            xact(1'b1, 1'b0, 8'h90, 8'h00, lat2);
        join
        order_chk("tie_after_core", 1'b1, 1'b0);

        xact(1'b0, 1'b1, 8'h10, 8'hA5, lat);
        chk("core_wr_latency", lat, 2);
        xact(1'b0, 1'b0, 8'h10, 8'h00, lat);
        chk("core_rd_latency", lat, 3);
        chk("core_rd_data", int'(coreReadData), 8'hA5);
        // Address is scrambled to 0x20 after grant; the next read really targets 0x20.
        xact(1'b0, 1'b0, 8'h10, 8'h00, lat);
        xact(1'b0, 1'b0, 8'h20, 8'h00, lat);
        xact(1'b1, 1'b0, 8'h90, 8'h00, lat);
        chk("load_rd_latency", lat, 3);
        chk("load_rd_data", int'(loadReadData), 8'h66);
        xact(1'b1, 1'b1, 8'h91, 8'hE7, lat);
        chk("load_wr_latency", lat, 2);
        chk("write_keeps_rdata", int'(loadReadData), 8'h66);

        hold_test();
        reset_test();
        xact(1'b0, 1'b0, 8'h40, 8'h00, lat);
        chk("aborted_write_read_lat", lat, 3);

        fork
            begin
                int l0;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    xact(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)),
                         8'($urandom), l0);
                end
            end
            begin
                int l1;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    xact(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)),
                         8'($urandom), l1);
                end
            end
        join
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
